// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: execute-stage forwarding selects,
// per-stage stall/flush controls with mem-wait and mul/div freeze states, and a stall counter.
module hazard_ctrl #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [RA_W-1:0]  rs1_addr_dec_i,
  input  logic [RA_W-1:0]  rs2_addr_dec_i,
  input  logic [RA_W-1:0]  rs1_addr_ex_i,
  input  logic [RA_W-1:0]  rs2_addr_ex_i,
  input  logic [RA_W-1:0]  rd_addr_ex_i,
  input  logic             load_ex_i,
  input  logic [RA_W-1:0]  rd_addr_mem_i,
  input  logic             rd_write_mem_i,
  input  logic [RA_W-1:0]  rd_addr_wb_i,
  input  logic             rd_write_wb_i,
  input  logic             taken_ex_i,
  input  logic             md_busy_ex_i,
  input  logic             md_done_i,
  input  logic             dmem_req_mem_i,
  input  logic             dmem_ready_i,
  input  logic             perf_clr_i,
  output logic [1:0]       fwd_src1_o,
  output logic [1:0]       fwd_src2_o,
  output logic             pc_stall_o,
  output logic             fe_stall_o,
  output logic             dec_stall_o,
  output logic             ex_stall_o,
  output logic             flush_fe_o,
  output logic             flush_dec_o,
  output logic             flush_ex_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StMemWait, StMdWait} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pc_stall, fe_stall, dec_stall, ex_stall;
  logic               flush_fe, flush_dec, flush_ex;
  logic               mem_wait, md_wait, load_use;

  // x0 is hardwired to zero, so a write to it never produces forwardable data.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic [RA_W-1:0] rd_mem, input logic wr_mem,
                                         input logic [RA_W-1:0] rd_wb, input logic wr_wb);
    if (wr_mem && (rd_mem != '0) && (rd_mem == rs)) begin
      return 2'b01;
    end else if (wr_wb && (rd_wb != '0) && (rd_wb == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign fwd_src1_o = rst_ni ? fwd_sel(rs1_addr_ex_i, rd_addr_mem_i, rd_write_mem_i,
                                       rd_addr_wb_i, rd_write_wb_i) : 2'b00;
  assign fwd_src2_o = rst_ni ? fwd_sel(rs2_addr_ex_i, rd_addr_mem_i, rd_write_mem_i,
                                       rd_addr_wb_i, rd_write_wb_i) : 2'b00;

  assign md_wait  = md_busy_ex_i & ~md_done_i;
  assign load_use = load_ex_i & (rd_addr_ex_i != '0) &
                    ((rd_addr_ex_i == rs1_addr_dec_i) | (rd_addr_ex_i == rs2_addr_dec_i));
  // Once waiting on memory only dmem_ready matters; the request is assumed held.
  assign mem_wait = (state_q == StMemWait) ? ~dmem_ready_i : (dmem_req_mem_i & ~dmem_ready_i);

  always_comb begin
    state_d   = state_q;
    pc_stall  = 1'b0;
    fe_stall  = 1'b0;
    dec_stall = 1'b0;
    ex_stall  = 1'b0;
    flush_fe  = 1'b0;
    flush_dec = 1'b0;
    flush_ex  = 1'b0;
    case (state_q)
      StRun, StMemWait: begin
        state_d = StRun;
        if (mem_wait) begin
          {pc_stall, fe_stall, dec_stall, ex_stall} = 4'b1111;
          state_d = StMemWait;
        end else if (md_wait) begin
          {pc_stall, fe_stall, dec_stall, ex_stall} = 4'b1111;
          flush_ex = 1'b1;
          state_d  = StMdWait;
        end else if (taken_ex_i) begin
          flush_fe  = 1'b1;
          flush_dec = 1'b1;
        end else if (load_use) begin
          pc_stall  = 1'b1;
          fe_stall  = 1'b1;
          flush_dec = 1'b1;
        end
      end
      StMdWait: begin
        // Execute holds the mul/div, so branch and load-use cannot apply here.
        if (!md_done_i) begin
          {pc_stall, fe_stall, dec_stall, ex_stall} = 4'b1111;
          flush_ex = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign pc_stall_o  = rst_ni & pc_stall;
  assign fe_stall_o  = rst_ni & fe_stall;
  assign dec_stall_o = rst_ni & dec_stall;
  assign ex_stall_o  = rst_ni & ex_stall;
  assign flush_fe_o  = rst_ni & flush_fe;
  assign flush_dec_o = rst_ni & flush_dec;
  assign flush_ex_o  = rst_ni & flush_ex;

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr_i) begin
      cnt_d = '0;
    end else if (pc_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [RA_W-1:0] rs1_dec, rs2_dec, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic load_ex, wr_mem, wr_wb, taken, md_busy, md_done, dreq, drdy, perf_clr;

  logic [1:0]  f1, f2, f1b, f2b;
  logic        ps, fs, ds, es, ff, fd, fe;
  logic        psb, fsb, dsb, esb, ffb, fdb, feb;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_addr_dec_i(rs1_dec), .rs2_addr_dec_i(rs2_dec),
    .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex), .rd_addr_ex_i(rd_ex),
    .load_ex_i(load_ex), .rd_addr_mem_i(rd_mem), .rd_write_mem_i(wr_mem),
    .rd_addr_wb_i(rd_wb), .rd_write_wb_i(wr_wb), .taken_ex_i(taken),
    .md_busy_ex_i(md_busy), .md_done_i(md_done), .dmem_req_mem_i(dreq),
    .dmem_ready_i(drdy), .perf_clr_i(perf_clr),
    .fwd_src1_o(f1), .fwd_src2_o(f2), .pc_stall_o(ps), .fe_stall_o(fs),
    .dec_stall_o(ds), .ex_stall_o(es), .flush_fe_o(ff), .flush_dec_o(fd),
    .flush_ex_o(fe), .stall_cnt_o(cnt16)
  );

  hazard_ctrl #(.RA_W(RA_W), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_addr_dec_i(rs1_dec), .rs2_addr_dec_i(rs2_dec),
    .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex), .rd_addr_ex_i(rd_ex),
    .load_ex_i(load_ex), .rd_addr_mem_i(rd_mem), .rd_write_mem_i(wr_mem),
    .rd_addr_wb_i(rd_wb), .rd_write_wb_i(wr_wb), .taken_ex_i(taken),
    .md_busy_ex_i(md_busy), .md_done_i(md_done), .dmem_req_mem_i(dreq),
    .dmem_ready_i(drdy), .perf_clr_i(perf_clr),
    .fwd_src1_o(f1b), .fwd_src2_o(f2b), .pc_stall_o(psb), .fe_stall_o(fsb),
    .dec_stall_o(dsb), .ex_stall_o(esb), .flush_fe_o(ffb), .flush_dec_o(fdb),
    .flush_ex_o(feb), .stall_cnt_o(cnt2)
  );

  // Model: what the pipeline is currently waiting for (0 nothing, 1 memory, 2 mul/div).
  typedef struct packed {
    logic [1:0] f1, f2;
    logic ps, fs, ds, es, ff, fd, fe;
    logic [1:0] wait_next;
  } exp_t;

  int m_wait = 0;
  int m_cnt16 = 0;
  int m_cnt2 = 0;

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
    if (rs == 0) return 2'd0;
    if (wr_mem && rd_mem == rs) return 2'd1;
    if (wr_wb && rd_wb == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model(input int waiting);
    exp_t e;
    bit freeze, md_freeze, mem_freeze;
    e = '0;
    if (!rst_n) return e;
    e.f1 = m_fwd(rs1_ex);
    e.f2 = m_fwd(rs2_ex);
    if (waiting == 2) begin
      md_freeze = !md_done;
      mem_freeze = 1'b0;
    end else begin
      mem_freeze = (waiting == 1) ? !drdy : (dreq && !drdy);
      md_freeze = !mem_freeze && md_busy && !md_done;
    end
    freeze = mem_freeze || md_freeze;
    {e.ps, e.fs, e.ds, e.es} = freeze ? 4'b1111 : 4'b0000;
    e.fe = md_freeze;
    e.wait_next = mem_freeze ? 2'd1 : (md_freeze ? 2'd2 : 2'd0);
    if (!freeze && waiting != 2) begin
      if (taken) begin
        e.ff = 1'b1;
        e.fd = 1'b1;
      end else if (load_ex && rd_ex != 0 && (rd_ex == rs1_dec || rd_ex == rs2_dec)) begin
        e.ps = 1'b1;
        e.fs = 1'b1;
        e.fd = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_wait <= 0;
      m_cnt16 <= 0;
      m_cnt2 <= 0;
    end else begin
      e = model(m_wait);
      m_wait <= int'(e.wait_next);
      if (perf_clr) begin
        m_cnt16 <= 0;
        m_cnt2 <= 0;
      end else if (e.ps) begin
        if (m_cnt16 < 65535) m_cnt16 <= m_cnt16 + 1;
        if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(taken && md_busy)) else $error("taken_ex and md_busy_ex both high");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model(m_wait);
      chk("fwd_src1", int'(f1), int'(e.f1));
      chk("fwd_src2", int'(f2), int'(e.f2));
      chk("stalls", int'({ps, fs, ds, es}), int'({e.ps, e.fs, e.ds, e.es}));
      chk("flushes", int'({ff, fd, fe}), int'({e.ff, e.fd, e.fe}));
      chk("stall_cnt", int'(cnt16), m_cnt16);
      chk("stall_cnt_sat", int'(cnt2), m_cnt2);
      chk("sat_pc_stall", int'(psb), int'(e.ps));
    end
  end

  task automatic clr_in();
    {rs1_dec, rs2_dec, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {load_ex, wr_mem, wr_wb, taken, md_busy, md_done, dreq, drdy, perf_clr} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic zero_cnt();
    clr_in();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    rs1_ex = 5; rd_mem = 5; wr_mem = 1; dreq = 1; md_busy = 1;
    #12;
    chk("reset_fwd1", int'(f1), 0);
    chk("reset_stalls", int'({ps, fs, ds, es, ff, fd, fe}), 0);
    chk("reset_cnt", int'(cnt16), 0);
    @(negedge clk);
    clr_in();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Forwarding
    tick();
    rs1_ex = 5; rd_mem = 5; wr_mem = 1; rd_wb = 5; wr_wb = 1;
    mid();
    chk("fwd_mem_prio", int'(f1), 1);
    tick();
    rs1_ex = 3; rs2_ex = 0; rd_mem = 0; wr_mem = 1; rd_wb = 3; wr_wb = 1;
    mid();
    chk("fwd_wb", int'(f1), 2);
    chk("fwd_x0", int'(f2), 0);

    // Load-use, then load-use masked by a branch
    zero_cnt();
    load_ex = 1; rd_ex = 7; rs2_dec = 7;
    mid();
    chk("lu_stall", int'({ps, fs, ds, es, ff, fd, fe}), 7'b1100010);
    tick();
    clr_in();
    mid();
    chk("lu_after", int'({ps, fs, fd}), 0);
    chk("lu_cnt", int'(cnt16), 1);
    load_ex = 1; rd_ex = 7; rs2_dec = 7; taken = 1;
    mid();
    chk("lu_branch", int'({ps, fs, ds, es, ff, fd, fe}), 7'b0000110);

    // Memory wait of 3 cycles
    zero_cnt();
    dreq = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("memw_stall", int'({ps, fs, ds, es, ff, fd, fe}), 7'b1111000);
      tick();
    end
    drdy = 1;
    mid();
    chk("memw_done", int'({ps, fs, ds, es}), 0);
    tick();
    clr_in();
    mid();
    chk("memw_cnt", int'(cnt16), 3);

    // Mul/div done on 4th cycle, then done immediately
    zero_cnt();
    md_busy = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("md_stall", int'({ps, fs, ds, es, ff, fd, fe}), 7'b1111001);
      tick();
    end
    md_done = 1;
    mid();
    chk("md_done", int'({ps, fs, ds, es, fe}), 0);
    tick();
    md_busy = 1; md_done = 1;
    mid();
    chk("md_immediate", int'({ps, fe}), 0);
    tick();
    clr_in();
    mid();
    chk("md_cnt", int'(cnt16), 3);

    // Back-to-back mem wait then mul/div
    zero_cnt();
    dreq = 1; md_busy = 1;
    mid();
    chk("b2b_c1", int'({ps, fs, ds, es, fe}), 5'b11110);
    tick();
    mid();
    chk("b2b_c2", int'({ps, fs, ds, es, fe}), 5'b11110);
    tick();
    drdy = 1;
    mid();
    chk("b2b_c3", int'({ps, fs, ds, es, fe}), 5'b11111);
    tick();
    dreq = 0; drdy = 0;
    mid();
    chk("b2b_c4", int'({ps, fs, ds, es, fe}), 5'b11111);
    tick();
    md_done = 1;
    mid();
    chk("b2b_c5", int'({ps, fe}), 0);
    tick();
    clr_in();
    mid();
    chk("b2b_cnt", int'(cnt16), 4);

    // Reset in the middle of a mul/div wait
    md_busy = 1;
    tick();
    rs1_ex = 5; rd_mem = 5; wr_mem = 1;
    mid();
    chk("rst_pre", int'({ps, fe}), 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", int'({ps, fs, ds, es, ff, fd, fe}), 0);
    chk("rst_async_fwd", int'(f1), 0);
    chk("rst_async_cnt", int'(cnt16), 0);
    @(negedge clk);
    md_busy = 0;
    rst_n = 1'b1;
    #1;
    chk("rst_run", int'({ps, fe}), 0);

    // Saturation of a 2-bit counter over 5 stall cycles, then clear
    zero_cnt();
    dreq = 1;
    repeat (5) tick();
    drdy = 1;
    tick();
    clr_in();
    mid();
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_cnt16", int'(cnt16), 5);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    mid();
    chk("clr_cnt", int'(cnt16), 0);
    chk("clr_cnt2", int'(cnt2), 0);

    // Randomized traffic; small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 199) != 0);
      rs1_dec = RA_W'($urandom_range(0, 3));
      rs2_dec = RA_W'($urandom_range(0, 3));
      rs1_ex = RA_W'($urandom_range(0, 3));
      rs2_ex = RA_W'($urandom_range(0, 3));
      rd_ex = RA_W'($urandom_range(0, 3));
      rd_mem = RA_W'($urandom_range(0, 3));
      rd_wb = RA_W'($urandom_range(0, 3));
      load_ex = $urandom_range(0, 2) == 0;
      wr_mem = $urandom_range(0, 1) == 0;
      wr_wb = $urandom_range(0, 1) == 0;
      md_busy = $urandom_range(0, 3) == 0;
      taken = !md_busy && ($urandom_range(0, 3) == 0);
      md_done = $urandom_range(0, 2) == 0;
      dreq = $urandom_range(0, 2) == 0;
      drdy = $urandom_range(0, 1) == 0;
      perf_clr = $urandom_range(0, 49) == 0;
    end
    @(posedge clk);
    #1;
    clr_in();
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32 core: it generates operand-forwarding selects for the execute stage, per-stage stall and flush controls, and a stall-cycle performance counter. Compared with the original hazard logic it adds:
- a register-address width parameter (RV32I/RV32E);
- x0 filtering;
- load-use detection against the decode stage;
- a state machine that freezes the pipeline for multi-cycle mul/div ops and for data-memory wait states.

It sits between the pipeline registers and the stage control inputs.

## Interface
Parameters:
- RA_W, 5: register address width (4 for RV32E).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr_dec, rs2_addr_dec  in  RA_W  source registers of the instruction in decode.
- rs1_addr_ex, rs2_addr_ex  in  RA_W  source registers of the instruction in execute.
- rd_addr_ex  in  RA_W  destination of the instruction in execute.
- load_ex  in  1  execute holds a load.
- rd_addr_mem, rd_write_mem  in  RA_W, 1  memory-stage destination and write enable.
- rd_addr_wb, rd_write_wb  in  RA_W, 1  writeback destination and write enable.
- taken_ex  in  1  branch/jump in execute redirects the PC.
- md_busy_ex  in  1  level signal: a mul/div op sits in execute and has no result yet.
- md_done  in  1  one-cycle pulse: mul/div result valid.
- dmem_req_mem  in  1  memory stage issues a data access.
- dmem_ready  in  1  data memory completes the access this cycle.
- perf_clr  in  1  synchronous clear of stall_cnt.
- fwd_src1, fwd_src2  out  2  operand select: 00 = RS_DATA, 01 = FWD_MEM, 10 = FWD_WB.
- pc_stall, fe_stall, dec_stall, ex_stall  out  1  hold the PC and the IF/ID, ID/EX, EX/MEM registers.
- flush_fe, flush_dec, flush_ex  out  1  load a bubble into IF/ID, ID/EX, EX/MEM.
- stall_cnt  out  CNT_W  number of cycles with pc_stall=1, saturating.

## Operation
Forwarding (combinational, independent of state), shown for src1 (src2 is identical with rs2):
- If rs1_addr_ex == rd_addr_mem & rd_write_mem & rd_addr_mem != 0, select 01.
- Else if the same match holds against wb, select 10.
- Else select 00.
- Register x0 is never forwarded.

State machine has three states: RUN, MEM_WAIT, MD_WAIT. Conditions are evaluated in RUN in priority order:
1. **Memory wait:** dmem_req_mem & !dmem_ready. Assert pc/fe/dec/ex stall; next state MEM_WAIT.
2. **Mul/div:** md_busy_ex & !md_done. Assert pc/fe/dec/ex stall and flush_ex (bubble into mem); next state MD_WAIT.
3. **Branch:** taken_ex. Assert flush_fe and flush_dec; stay in RUN.
4. **Load-use:** load_ex & rd_addr_ex != 0 & (rd_addr_ex == rs1_addr_dec | rd_addr_ex == rs2_addr_dec). Assert pc_stall, fe_stall and flush_dec for one cycle; stay in RUN.

Behaviour in the wait states:
- **MEM_WAIT:** while !dmem_ready, hold all four stalls and assert no flush. When dmem_ready=1, drop the memory condition and apply RUN rules 2–4 in that same cycle, including their next-state choice.
- **MD_WAIT:** while !md_done, behave as rule 2 (stalls plus flush_ex). When md_done=1, drop all stalls and flush_ex and return to RUN. taken_ex and load-use are ignored on the md_done cycle, because execute holds a mul/div.

Other rules:
- taken_ex and md_busy_ex are never high together, since they come from the same execute slot. A bench assertion checks this.
- A branch coinciding with a load-use hazard: the branch wins, with no stall, because the decode instruction is flushed.
- Counter: on each clock, stall_cnt <= 0 if perf_clr; otherwise it increments when pc_stall=1 and stall_cnt != all-ones. perf_clr has priority over the increment.

## Timing
- All stall, flush and fwd outputs are combinational from the current inputs and state. They take effect on the pipeline registers at the next rising clk.
- State and stall_cnt update on the rising clk.
- Load-use costs exactly 1 bubble.
- A branch costs 2 flushed slots.
- A mem wait of N cycles costs N stall cycles.
- A mul/div finishing at cycle k after entering execute stalls for k cycles.
- While rst_n=0 (asserted asynchronously):
  - state = RUN and stall_cnt = 0;
  - all stall and flush outputs are forced to 0;
  - fwd_src1 and fwd_src2 are forced to 00.
- On rst_n release, the first evaluation happens in RUN.
- Reset during MEM_WAIT or MD_WAIT aborts the wait immediately, with no residual stall.

## Test plan
- **Forwarding:** rs1_ex=5 with rd_mem=5/wr=1 and rd_wb=5/wr=1 → fwd_src1=01. rs2_ex=0 with rd_mem=0/wr=1 → fwd_src2=00.
- **Load-use:** load_ex=1, rd_ex=7, rs2_dec=7 → one cycle of pc_stall=fe_stall=flush_dec=1, then all 0; stall_cnt +1. Adding taken_ex=1 in the same cycle → flush_fe=flush_dec=1, no stall.
- **Memory wait:** dmem_req=1 with dmem_ready low for 3 cycles → pc/fe/dec/ex stall high for exactly 3 cycles, flushes 0, stall_cnt +3.
- **Mul/div:** md_busy_ex high, md_done pulses on the 4th cycle → stalls and flush_ex high for 3 cycles, then all 0. md_done in the first cycle → no stall.
- **Back-to-back waits:** mem wait of 2 cycles with md_busy_ex=1 → MEM_WAIT, then MD_WAIT directly on the dmem_ready cycle, with stalls continuous throughout.
- **Reset and saturation:**
  - rst_n pulled low mid-MD_WAIT → all outputs 0 immediately; RUN after release.
  - With CNT_W=2 and 5 stall cycles → stall_cnt stops at 3.
  - perf_clr → 0.
